// File: rtl/param_stream_mux.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Selection is by address (MODE 0) or round-robin (MODE 1) and is held for a whole packet.
module param_stream_mux #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_ch
);

    logic             lock;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] rr_ptr;
    logic             load_en;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W:0]   rr_idx;
    logic             xfer;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_last;
    logic [SEL_W-1:0] rr_next;

    assign load_en = !out_valid || out_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        rr_idx  = '0;
        if (lock) begin
            gnt_vld = 1'b1;
            gnt     = lock_ch;
        end else if (MODE == 0) begin
            gnt     = sel;
            gnt_vld = ({1'b0, sel} < (SEL_W+1)'(NUM_CH));
        end else begin
            // Scan offsets high to low so the smallest offset from rr_ptr wins.
            for (int k = NUM_CH-1; k >= 0; k--) begin
                rr_idx = {1'b0, rr_ptr} + (SEL_W+1)'(k);
                if (rr_idx >= (SEL_W+1)'(NUM_CH))
                    rr_idx = rr_idx - (SEL_W+1)'(NUM_CH);
                if (in_valid[rr_idx[SEL_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt     = rr_idx[SEL_W-1:0];
                end
            end
        end
    end

    // Reset also blocks in_ready so producers never see a handshake while held in reset.
    always_comb begin
        in_ready  = '0;
        xfer_data = '0;
        xfer_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                in_ready[i] = reset_n && load_en && gnt_vld;
                xfer_data   = in_data[i*WIDTH +: WIDTH];
                xfer_last   = in_last[i];
            end
        end
    end

    assign xfer    = |(in_valid & in_ready);
    assign rr_next = (gnt == SEL_W'(NUM_CH-1)) ? '0 : gnt + SEL_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            lock      <= 1'b0;
            lock_ch   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= xfer_data;
                out_last  <= xfer_last;
                out_ch    <= gnt;
                if (xfer_last) begin
                    lock <= 1'b0;
                    if (MODE == 1)
                        rr_ptr <= rr_next;
                end else begin
                    lock    <= 1'b1;
                    lock_ch <= gnt;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_stream_mux.sv
// Bench for param_stream_mux: one address-select and one round-robin instance on shared stimulus.
module tb_param_stream_mux;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_last = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b1;
    logic [N-1:0]   rdy0, rdy1;
    logic           ov0, ov1, ol0, ol1;
    logic [W-1:0]   od0, od1;
    logic [SW-1:0]  och0, och1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    param_stream_mux #(.NUM_CH(N), .WIDTH(W), .SEL_W(SW), .MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .sel(sel), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_last(ol0), .out_ch(och0));

    param_stream_mux #(.NUM_CH(N), .WIDTH(W), .SEL_W(SW), .MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .sel(sel), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_last(ol1), .out_ch(och1));

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [3:0]  last;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic [1:0]  e_och;
    } vec_t;

    vec_t tbl[12];

    // Reference state per mode: output register contents, packet lock and round-robin pointer.
    int m_ov[2], m_od[2], m_ol[2], m_och[2], m_lock[2], m_lch[2], m_rr[2];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ov[m] = 0; m_od[m] = 0; m_ol[m] = 0; m_och[m] = 0;
            m_lock[m] = 0; m_lch[m] = 0; m_rr[m] = 0;
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = '0;
        in_last  = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    function automatic int model_grant(input int m);
        if (m_lock[m] != 0) return m_lch[m];
        if (m == 0) return (int'(sel) < N) ? int'(sel) : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_rr[m] + k) % N]) return (m_rr[m] + k) % N;
        end
        return -1;
    endfunction

    function automatic int model_rdy(input int m);
        int g;
        g = model_grant(m);
        if ((m_ov[m] == 0 || out_ready) && g >= 0) return 1 << g;
        return 0;
    endfunction

    task automatic model_step(input int m);
        int g;
        bit load;
        g = model_grant(m);
        load = (m_ov[m] == 0) || out_ready;
        if (load && g >= 0 && in_valid[g]) begin
            m_ov[m]  = 1;
            m_od[m]  = int'(in_data[g*W +: W]);
            m_ol[m]  = int'(in_last[g]);
            m_och[m] = g;
            if (in_last[g]) begin
                m_lock[m] = 0;
                if (m == 1) m_rr[m] = (g + 1) % N;
            end else begin
                m_lock[m] = 1;
                m_lch[m]  = g;
            end
        end else if (out_ready) begin
            m_ov[m] = 0;
        end
    endtask

    initial begin
        tbl[0]  = '{2'd1, 4'b0010, 4'b0000, 1'b1, 32'h3300_1100, 4'b0010, 1'b1, 8'h11, 1'b0, 2'd1};
        tbl[1]  = '{2'd3, 4'b1010, 4'b0000, 1'b1, 32'h3300_1200, 4'b0010, 1'b1, 8'h12, 1'b0, 2'd1};
        tbl[2]  = '{2'd3, 4'b1010, 4'b0010, 1'b1, 32'h3300_1300, 4'b0010, 1'b1, 8'h13, 1'b1, 2'd1};
        tbl[3]  = '{2'd3, 4'b1000, 4'b1000, 1'b1, 32'h3C00_0000, 4'b1000, 1'b1, 8'h3C, 1'b1, 2'd3};
        for (int i = 4; i < 9; i++)
            tbl[i] = '{2'd3, 4'b1000, 4'b1000, 1'b0, 32'h3D00_0000, 4'b0000, 1'b1, 8'h3C, 1'b1, 2'd3};
        tbl[9]  = '{2'd3, 4'b1000, 4'b1000, 1'b1, 32'h3D00_0000, 4'b1000, 1'b1, 8'h3D, 1'b1, 2'd3};
        tbl[10] = '{2'd3, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 4'b1000, 1'b0, 8'h3D, 1'b1, 2'd3};
        tbl[11] = '{2'd0, 4'b0001, 4'b0001, 1'b0, 32'h0000_005A, 4'b0001, 1'b1, 8'h5A, 1'b1, 2'd0};

        // Reset holds everything idle even with all channels valid.
        reset_n = 1'b0; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        sel = 2'd2; in_data = 32'h00A5_0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_ov", ov0, 0);
            chk("rst_od", od0, 0);
            chk("rst_och", och0, 0);
            chk("rst_rdy0", rdy0, 0);
            chk("rst_rdy1", rdy1, 0);
        end
        reset_n = 1'b1; in_valid = 4'b0100; in_last = 4'b0100;
        #1 chk("rel_rdy", rdy0, 4'b0100);
        tick();
        chk("rel_od", od0, 8'hA5);
        chk("rel_och", och0, 2);
        chk("rel_ol", ol0, 1);
        chk("rel_ov", ov0, 1);
        in_valid = '0;
        tick();
        chk("drain_ov", ov0, 0);

        // Packet lock, backpressure and refill through the address-select instance.
        for (int i = 0; i < 12; i++) begin
            sel = tbl[i].sel; in_valid = tbl[i].vld; in_last = tbl[i].last;
            out_ready = tbl[i].ordy; in_data = tbl[i].data;
            #1 chk($sformatf("tbl%0d_rdy", i), rdy0, tbl[i].e_rdy);
            tick();
            chk($sformatf("tbl%0d_ov", i), ov0, tbl[i].e_ov);
            chk($sformatf("tbl%0d_od", i), od0, tbl[i].e_od);
            chk($sformatf("tbl%0d_ol", i), ol0, tbl[i].e_ol);
            chk($sformatf("tbl%0d_och", i), och0, tbl[i].e_och);
        end

        // Locked channel goes idle, then reset discards the lock.
        out_ready = 1'b1;
        do_reset();
        sel = 2'd2; in_valid = 4'b0100; in_last = 4'b0000; in_data = 32'h0021_0000;
        #1 chk("lk_rdy", rdy0, 4'b0100);
        tick();
        chk("lk_och", och0, 2);
        chk("lk_od", od0, 8'h21);
        chk("lk_ol", ol0, 0);
        sel = 2'd0; in_valid = 4'b0001; in_last = 4'b0001; in_data = 32'h0000_000F;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall_rdy", rdy0, 4'b0100);
            tick();
            chk("stall_ov", ov0, 0);
            chk("stall_och", och0, 2);
        end
        reset_n = 1'b0;
        #1 chk("mrst_rdy", rdy0, 0);
        tick();
        chk("mrst_ov", ov0, 0);
        reset_n = 1'b1;
        #1 chk("mrst_rel_rdy", rdy0, 4'b0001);
        tick();
        chk("mrst_och", och0, 0);
        chk("mrst_od", od0, 8'h0F);
        chk("mrst_ov1", ov0, 1);

        // Random traffic against the reference model on both instances.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid = 4'($urandom_range(0, 15));
            for (int b = 0; b < N; b++) in_last[b] = ($urandom_range(0, 2) == 0);
            in_data   = $urandom();
            sel       = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_rdy0", rdy0, model_rdy(0));
            chk("rnd_rdy1", rdy1, model_rdy(1));
            model_step(0);
            model_step(1);
            tick();
            chk("rnd_ov0", ov0, m_ov[0]);
            chk("rnd_od0", od0, m_od[0]);
            chk("rnd_ol0", ol0, m_ol[0]);
            chk("rnd_och0", och0, m_och[0]);
            chk("rnd_ov1", ov1, m_ov[1]);
            chk("rnd_od1", od1, m_od[1]);
            chk("rnd_ol1", ol1, m_ol[1]);
            chk("rnd_och1", och1, m_och[1]);
        end

        // Round-robin fairness with single-beat packets from every channel.
        out_ready = 1'b1;
        do_reset();
        in_valid = 4'hF; in_last = 4'hF; in_data = 32'h4433_2211;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_och", och1, k % 4);
            chk("rr_ov", ov1, 1);
            chk("rr_od", od1, 8'h11 * (k % 4 + 1));
        end

        // Pointer wrap and skip of idle channels.
        in_valid = 4'b0100;
        #1 chk("wrap_rdy_a", rdy1, 4'b0100);
        tick();
        chk("wrap_och_a", och1, 2);
        in_valid = 4'b0010;
        #1 chk("wrap_rdy_b", rdy1, 4'b0010);
        tick();
        chk("wrap_och_b", och1, 1);
        in_valid = 4'b0101;
        #1 chk("wrap_rdy_c", rdy1, 4'b0100);
        tick();
        chk("wrap_och_c", och1, 2);
        in_valid = 4'b0000;
        #1 chk("wrap_rdy_none", rdy1, 0);
        tick();
        chk("wrap_ov_none", ov1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
